// File: rtl/orb_pkg.sv
// ----------------------------------------------------------------------------
// orb_pkg
// Shared types and constants for the orbit frame read-out path.
//   orbState_t : read-out sequencer states (IDLE, SWAP, READ, DRAIN)
//   WORD_W     : width of one frame-store word
//   ADDR_W     : width of the frame-store word index
//   CSUM_W     : width of the optional modulo-4096 frame checksum
// ----------------------------------------------------------------------------
package orb_pkg;

    localparam int WORD_W = 12;
    localparam int ADDR_W = 11;
    localparam int CSUM_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWAP  = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } orbState_t;

endpackage

// File: rtl/orb_skid_fifo.sv
// ----------------------------------------------------------------------------
// orb_skid_fifo
// Small synchronous FIFO that absorbs transmitter back-pressure. The entry at
// the head is mirrored into a dedicated register so the stream data output
// comes straight from a flop.
// Parameters: DEPTH (power of two, >= 2), WIDTH (data bits).
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   push      : write pushData this cycle (dropped if full and not popping)
//   pushData  : write data
//   pop       : remove the head entry (ignored when empty)
//   headData  : registered head entry, 0 after reset
//   empty     : no entries
//   full      : DEPTH entries
//   count     : current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module orb_skid_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 12,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] rdNext;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdNext = rdPtr + 1'b1;

    // NOTE: the storage array carries no reset; pointers and count define
    // which entries are meaningful, so clearing the data buys nothing.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // NOTE: every register here uses <= so all updates see pre-edge values,
    // e.g. the head reload reads mem before this edge's write lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            headData <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdNext;
            end
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);

            // The head register follows whatever becomes the front entry:
            // the incoming word when the FIFO is (or is becoming) empty,
            // otherwise the next stored entry behind the popped one.
            if (doPush && (empty || (count == CNT_W'(1) && doPop))) begin
                headData <= pushData;
            end else if (doPop && count > CNT_W'(1)) begin
                headData <= mem[rdNext];
            end
        end
    end

endmodule

// File: rtl/orb_frame_reader.sv
// ----------------------------------------------------------------------------
// orb_frame_reader
// Read-out stage for the ping-pong orbit frame store. Per frame it flips the
// bank select, waits GUARD cycles, reads FRAME_WORDS words in address order
// and streams them out over valid/ready through a credit-limited skid FIFO.
// Optional feature macro: ORB_CHECKSUM_EN -- appends a 12-bit additive
// checksum word after the last data word of each frame.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   frmStart    : one-cycle pulse, the current write bank is complete
//   orbData     : frame-store read data, valid RD_LAT cycles after RE
//   SW          : bank select, toggles once per accepted frmStart
//   RE, rAddr   : frame-store read enable and word index
//   outWord     : stream data (FIFO head)
//   outValid    : stream valid (FIFO not empty)
//   outReady    : stream ready from the transmitter
//   frameDone   : one-cycle pulse after the frame's final word is accepted
//   overrun     : sticky, frmStart seen while busy
// ----------------------------------------------------------------------------
module orb_frame_reader
    import orb_pkg::*;
#(
    parameter int FRAME_WORDS = 2048,
    parameter int RD_LAT      = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int GUARD       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frmStart,
    input  logic [WORD_W-1:0] orbData,
    output logic              SW,
    output logic              RE,
    output logic [ADDR_W-1:0] rAddr,
    output logic [WORD_W-1:0] outWord,
    output logic              outValid,
    input  logic              outReady,
    output logic              frameDone,
    output logic              overrun
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int GUARD_W = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    orbState_t           state;
    logic [GUARD_W-1:0]  guardCnt;
    logic [ADDR_W-1:0]   addrCnt;
    logic [RD_LAT-1:0]   rePipe;
    logic [3:0]          inFlight;
    logic                creditOk;
    logic                pop;
    logic                lastPop;
    logic                allPushed;
    logic                fifoPush;
    logic [WORD_W-1:0]   pushData;
    logic                fifoEmpty;
    logic                fifoFull;
    logic [CNT_W-1:0]    fifoCount;

    // In-flight reads: population of the RE delay line.
    // NOTE: always_comb assigns a default before the loop so no path leaves
    // inFlight unassigned, which would otherwise infer a latch.
    always_comb begin
        inFlight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inFlight = inFlight + 4'(rePipe[i]);
        end
    end

    assign pop      = outValid && outReady;
    assign outValid = !fifoEmpty;

    // A read may issue only if every word already owed to the FIFO, plus
    // this one, fits once the current pop has freed its slot. The credit
    // check depends on this cycle's pop, so RE is decoded combinationally
    // from registered state; that is what lets reads stream back-to-back
    // whenever FIFO_DEPTH exceeds RD_LAT.
    assign creditOk = (int'(inFlight) + int'(fifoCount)) < (FIFO_DEPTH + int'(pop));
    assign RE       = (state == READ) && creditOk;
    assign rAddr    = addrCnt;

    // The tail of the RE delay line marks orbData as the word read RD_LAT
    // cycles ago.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rePipe <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                rePipe[i] <= rePipe[i-1];
            end
            rePipe[0] <= RE;
        end
    end

`ifdef ORB_CHECKSUM_EN
    logic [CSUM_W-1:0] csum;
    logic              csumSent;
    logic              csumPush;

    // The checksum enters the FIFO once every data word has landed in it.
    assign csumPush  = (state == DRAIN) && !csumSent && (inFlight == '0) && !fifoFull;
    assign fifoPush  = rePipe[RD_LAT-1] || csumPush;
    assign pushData  = csumPush ? csum : orbData;
    assign allPushed = csumSent;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum     <= '0;
            csumSent <= 1'b0;
        end else if (state == IDLE && frmStart) begin
            csum     <= '0;
            csumSent <= 1'b0;
        end else begin
            if (rePipe[RD_LAT-1]) begin
                csum <= csum + orbData;
            end
            if (csumPush) begin
                csumSent <= 1'b1;
            end
        end
    end
`else
    assign fifoPush  = rePipe[RD_LAT-1];
    assign pushData  = orbData;
    assign allPushed = 1'b1;
`endif

    // Final handshake of the frame: nothing owed, nothing left to push and
    // the last FIFO entry leaving now.
    assign lastPop = (state == DRAIN) && allPushed && (inFlight == '0)
                     && (fifoCount == CNT_W'(1)) && pop;

    orb_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush),
        .pushData (pushData),
        .pop      (pop),
        .headData (outWord),
        .empty    (fifoEmpty),
        .full     (fifoFull),
        .count    (fifoCount)
    );

    // Credit accounting guarantees room for every returning word.
    assert property (@(posedge clk) disable iff (!rst) !(fifoPush && fifoFull));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            SW        <= 1'b0;
            guardCnt  <= '0;
            addrCnt   <= '0;
            frameDone <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (frmStart && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (frmStart) begin
                        SW       <= ~SW;
                        guardCnt <= GUARD_W'(GUARD);
                        state    <= SWAP;
                    end
                end
                SWAP: begin
                    if (guardCnt == '0) begin
                        addrCnt <= '0;
                        state   <= READ;
                    end else begin
                        guardCnt <= guardCnt - 1'b1;
                    end
                end
                READ: begin
                    if (RE) begin
                        // rAddr parks on the last address; no wrap.
                        if (addrCnt == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            addrCnt <= addrCnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (lastPop) begin
                        frameDone <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
